pe_pipe: RTL and testbench

- Next-generation processing element for the SMA array, parametrised in datapath width and pipeline depth.
- Holds its own configuration in a serial shift chain with a shadow/active double buffer, so the array can be reconfigured while it runs.
- Adds an accumulate mode, a valid-tracked output pipeline and locally masked diagonal-link outputs.
- One instance per array site. The CONF chain links neighbouring PEs.

---
 rtl/pe_pipe_pkg.sv | 38 +++
 rtl/pe_alu.sv | 43 ++++
 rtl/pe_pipe.sv | 161 ++++++++++++++++
 tb/tb_pe_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pipe_pkg.sv
// Shared definitions for the SMA processing element: configuration field layout,
// opcode and operand-select encodings.
package pe_pipe_pkg;

  localparam int unsigned CONF_W_MIN = 13;

  localparam int unsigned OP_LSB    = 0;
  localparam int unsigned SEL_A_LSB = 3;
  localparam int unsigned SEL_B_LSB = 6;
  localparam int unsigned DL_N_BIT  = 9;
  localparam int unsigned DL_NE_BIT = 10;
  localparam int unsigned DL_NW_BIT = 11;
  localparam int unsigned SAT_BIT   = 12;

  typedef enum logic [2:0] {
    OpPass = 3'd0,
    OpAdd  = 3'd1,
    OpSub  = 3'd2,
    OpAnd  = 3'd3,
    OpOr   = 3'd4,
    OpXor  = 3'd5,
    OpShl  = 3'd6,
    OpAcc  = 3'd7
  } op_e;

  // SelConst picks CONST_A for operand A and CONST_B for operand B.
  typedef enum logic [2:0] {
    SelSouth = 3'd0,
    SelEast  = 3'd1,
    SelWest  = 3'd2,
    SelNorth = 3'd3,
    SelDlS   = 3'd4,
    SelDlSe  = 3'd5,
    SelDlSw  = 3'd6,
    SelConst = 3'd7
  } sel_e;

endpackage

// File: rtl/pe_alu.sv
// Combinational ALU of the processing element. In accumulate mode the result is the
// next accumulator value (acc_i + a_i), saturating like ADD.
module pe_alu
  import pe_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 25
) (
  input  op_e               op_i,
  input  logic              sat_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] acc_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] add_src;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [4:0]        shamt;

  always_comb begin
    add_src = (op_i == OpAcc) ? acc_i : b_i;
    sum     = {1'b0, add_src} + {1'b0, a_i};
    diff    = {1'b0, a_i} - {1'b0, b_i};
    shamt   = b_i[4:0];
  end

  always_comb begin
    result_o = '0;
    unique case (op_i)
      OpPass: result_o = a_i;
      OpAdd,
      OpAcc:  result_o = (sat_i && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
      OpSub:  result_o = (sat_i && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
      OpAnd:  result_o = a_i & b_i;
      OpOr:   result_o = a_i | b_i;
      OpXor:  result_o = a_i ^ b_i;
      OpShl:  result_o = (32'(shamt) >= DATA_W) ? '0 : (a_i << shamt);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/pe_pipe.sv
// SMA processing element: serial shadow/active configuration, operand select, ALU,
// accumulator, valid-tracked output pipeline and masked diagonal-link outputs.
module pe_pipe
  import pe_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 25,
  parameter int unsigned LAT    = 1,
  parameter int unsigned CONF_W = 16
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              CONF_EN,
  input  logic              CONF_IN,
  output logic              CONF_OUT,
  input  logic              CONF_COMMIT,
  input  logic              RUN,
  input  logic              IN_VALID,
  input  logic              CLR_ACC,
  input  logic [DATA_W-1:0] IN_NORTH,
  input  logic [DATA_W-1:0] IN_SOUTH,
  input  logic [DATA_W-1:0] IN_EAST,
  input  logic [DATA_W-1:0] IN_WEST,
  input  logic [DATA_W-1:0] IN_DL_S,
  input  logic [DATA_W-1:0] IN_DL_SE,
  input  logic [DATA_W-1:0] IN_DL_SW,
  input  logic [DATA_W-1:0] IN_CONST_A,
  input  logic [DATA_W-1:0] IN_CONST_B,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DL_N,
  output logic [DATA_W-1:0] OUT_DL_NE,
  output logic [DATA_W-1:0] OUT_DL_NW
);

  logic [CONF_W-1:0] shadow_q, shadow_d;
  logic [CONF_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  op_e               op;
  sel_e              sel_a, sel_b;
  logic              sat;
  logic [DATA_W-1:0] opnd_a, opnd_b, acc_in, alu_res;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              acc_upd;

  // Commit reads shadow_q, so a simultaneous shift still commits the pre-shift word.
  always_comb begin
    shadow_d = CONF_EN ? {shadow_q[CONF_W-2:0], CONF_IN} : shadow_q;
    active_d = CONF_COMMIT ? shadow_q : active_q;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      shadow_q <= '0;
      active_q <= '0;
      acc_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      acc_q    <= acc_d;
    end
  end

  assign CONF_OUT = shadow_q[CONF_W-1];

  always_comb begin
    op    = op_e'(active_q[OP_LSB +: 3]);
    sel_a = sel_e'(active_q[SEL_A_LSB +: 3]);
    sel_b = sel_e'(active_q[SEL_B_LSB +: 3]);
    sat   = active_q[SAT_BIT];
  end

  always_comb begin
    opnd_a = '0;
    unique case (sel_a)
      SelSouth: opnd_a = IN_SOUTH;
      SelEast:  opnd_a = IN_EAST;
      SelWest:  opnd_a = IN_WEST;
      SelNorth: opnd_a = IN_NORTH;
      SelDlS:   opnd_a = IN_DL_S;
      SelDlSe:  opnd_a = IN_DL_SE;
      SelDlSw:  opnd_a = IN_DL_SW;
      SelConst: opnd_a = IN_CONST_A;
      default:  opnd_a = '0;
    endcase
    opnd_b = '0;
    unique case (sel_b)
      SelSouth: opnd_b = IN_SOUTH;
      SelEast:  opnd_b = IN_EAST;
      SelWest:  opnd_b = IN_WEST;
      SelNorth: opnd_b = IN_NORTH;
      SelDlS:   opnd_b = IN_DL_S;
      SelDlSe:  opnd_b = IN_DL_SE;
      SelDlSw:  opnd_b = IN_DL_SW;
      SelConst: opnd_b = IN_CONST_B;
      default:  opnd_b = '0;
    endcase
  end

  // A clear presented with a valid ACC beat restarts the sum from A.
  always_comb begin
    acc_upd = RUN & IN_VALID & (op == OpAcc);
    acc_in  = CLR_ACC ? '0 : acc_q;
    if (acc_upd) begin
      acc_d = alu_res;
    end else if (CLR_ACC) begin
      acc_d = '0;
    end else begin
      acc_d = acc_q;
    end
  end

  pe_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i     (op),
    .sat_i    (sat),
    .a_i      (opnd_a),
    .b_i      (opnd_b),
    .acc_i    (acc_in),
    .result_o (alu_res)
  );

  if (LAT == 0) begin : g_comb
    assign out_data  = alu_res;
    assign out_valid = IN_VALID & RUN;
  end else begin : g_pipe
    logic [DATA_W-1:0] stage_q [LAT];
    logic [LAT-1:0]    v_q;

    always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
        for (int unsigned i = 0; i < LAT; i++) stage_q[i] <= '0;
        v_q <= '0;
      end else if (RUN) begin
        stage_q[0] <= alu_res;
        v_q[0]     <= IN_VALID;
        for (int unsigned i = 1; i < LAT; i++) begin
          stage_q[i] <= stage_q[i-1];
          v_q[i]     <= v_q[i-1];
        end
      end
    end

    assign out_data  = stage_q[LAT-1];
    assign out_valid = v_q[LAT-1];
  end

  if (CONF_W > CONF_W_MIN) begin : g_rsvd
    logic unused_rsvd;
    assign unused_rsvd = ^active_q[CONF_W-1:CONF_W_MIN];
  end

  assign OUT_DATA  = out_data;
  assign OUT_VALID = out_valid;
  assign OUT_DL_N  = active_q[DL_N_BIT]  ? out_data : '0;
  assign OUT_DL_NE = active_q[DL_NE_BIT] ? out_data : '0;
  assign OUT_DL_NW = active_q[DL_NW_BIT] ? out_data : '0;

endmodule

// File: tb/tb_pe_pipe.sv
// Directed bench for pe_pipe: a LAT=1 and a LAT=3 instance share all stimulus;
// expected results are queued when driven and checked as each pipeline emits them.
module tb_pe_pipe;
  localparam int W = 25;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic conf_en, conf_in, conf_commit, run, in_valid, clr_acc;
  logic [W-1:0] in_n, in_s, in_e, in_w, in_dls, in_dlse, in_dlsw, ca, cb;
  logic         conf_out1, conf_out3, o1_valid, o3_valid;
  logic [W-1:0] o1_data, o1_dln, o1_dlne, o1_dlnw;
  logic [W-1:0] o3_data, o3_dln, o3_dlne, o3_dlnw;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] sb1[$];
  logic         exp_v1;
  logic         p3v [3];
  logic [W-1:0] p3d [3];

  pe_pipe #(.DATA_W(W), .LAT(1), .CONF_W(16)) dut1 (
    .CLK(clk), .RST_X(rst_n), .CONF_EN(conf_en), .CONF_IN(conf_in), .CONF_OUT(conf_out1),
    .CONF_COMMIT(conf_commit), .RUN(run), .IN_VALID(in_valid), .CLR_ACC(clr_acc),
    .IN_NORTH(in_n), .IN_SOUTH(in_s), .IN_EAST(in_e), .IN_WEST(in_w), .IN_DL_S(in_dls),
    .IN_DL_SE(in_dlse), .IN_DL_SW(in_dlsw), .IN_CONST_A(ca), .IN_CONST_B(cb),
    .OUT_DATA(o1_data), .OUT_VALID(o1_valid), .OUT_DL_N(o1_dln), .OUT_DL_NE(o1_dlne),
    .OUT_DL_NW(o1_dlnw)
  );

  pe_pipe #(.DATA_W(W), .LAT(3), .CONF_W(16)) dut3 (
    .CLK(clk), .RST_X(rst_n), .CONF_EN(conf_en), .CONF_IN(conf_in), .CONF_OUT(conf_out3),
    .CONF_COMMIT(conf_commit), .RUN(run), .IN_VALID(in_valid), .CLR_ACC(clr_acc),
    .IN_NORTH(in_n), .IN_SOUTH(in_s), .IN_EAST(in_e), .IN_WEST(in_w), .IN_DL_S(in_dls),
    .IN_DL_SE(in_dlse), .IN_DL_SW(in_dlsw), .IN_CONST_A(ca), .IN_CONST_B(cb),
    .OUT_DATA(o3_data), .OUT_VALID(o3_valid), .OUT_DL_N(o3_dln), .OUT_DL_NE(o3_dlne),
    .OUT_DL_NW(o3_dlnw)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] cfg(input logic [2:0] op, input logic [2:0] sa,
                                      input logic [2:0] sb, input logic dln,
                                      input logic dlne, input logic dlnw, input logic sat);
    return {3'b000, sat, dlnw, dlne, dln, sb, sa, op};
  endfunction

  task automatic reset_model();
    sb1.delete();
    exp_v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p3v[i] = 1'b0;
      p3d[i] = '0;
    end
  endtask

  // One clock with the given valid/run; expd is the ALU result for the current inputs.
  task automatic step(input logic v, input logic r, input logic [W-1:0] expd);
    logic [W-1:0] want;
    in_valid = v;
    run      = r;
    if (r && v) sb1.push_back(expd);
    @(posedge clk);
    #1;
    if (r) begin
      exp_v1 = v;
      for (int i = 2; i > 0; i--) begin
        p3v[i] = p3v[i-1];
        p3d[i] = p3d[i-1];
      end
      p3v[0] = v;
      p3d[0] = expd;
    end
    chkb("valid_lat1", o1_valid, exp_v1);
    if (r && o1_valid) begin
      n_assert++;
      assert (sb1.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_lat1_empty: observed 0 entries expected at least 1");
      end
      want = (sb1.size() != 0) ? sb1.pop_front() : '0;
      chk("data_lat1", o1_data, want);
    end
    chkb("valid_lat3", o3_valid, p3v[2]);
    if (p3v[2]) chk("data_lat3", o3_data, p3d[2]);
    conf_en     = 1'b0;
    conf_commit = 1'b0;
    clr_acc     = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] word, input logic do_commit);
    run      = 1'b0;
    in_valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      conf_en = 1'b1;
      conf_in = word[i];
      @(posedge clk);
      #1;
    end
    conf_en = 1'b0;
    chkb("conf_out", conf_out1, word[15]);
    if (do_commit) begin
      conf_commit = 1'b1;
      @(posedge clk);
      #1;
      conf_commit = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w_xor, w_b;
    rst_n = 1'b1;
    conf_en = 0; conf_in = 0; conf_commit = 0; run = 0; in_valid = 0; clr_acc = 0;
    in_n = '0; in_s = '0; in_e = '0; in_w = '0; in_dls = '0; in_dlse = '0; in_dlsw = '0;
    ca = '0; cb = '0;
    reset_model();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_data", o1_data, '0);
    chkb("rst_valid", o1_valid, 1'b0);
    chk("rst_dl_n", o1_dln, '0);
    chk("rst_dl_ne", o1_dlne, '0);
    chk("rst_dl_nw", o1_dlnw, '0);
    chkb("rst_conf_out", conf_out1, 1'b0);
    chkb("rst_valid3", o3_valid, 1'b0);
    chk("rst_dl3", o3_dln | o3_dlne | o3_dlnw, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD east + const_b, reserved bit 15 set and ignored
    load_cfg(16'h8000 | cfg(3'd1, 3'd1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    chkb("conf_out3", conf_out3, 1'b1);
    in_e = 25'h10; cb = 25'h5;
    step(1'b1, 1'b1, 25'h15);
    chk("dl_n_on", o1_dln, 25'h15);
    chk("dl_ne_off", o1_dlne, '0);
    chk("dl_nw_off", o1_dlnw, '0);
    in_e = 25'h1FFFFFF; cb = 25'h1;
    step(1'b1, 1'b1, 25'h0);

    load_cfg(cfg(3'd1, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    step(1'b1, 1'b1, 25'h1FFFFFF);
    chk("dl_n_masked", o1_dln, '0);

    load_cfg(cfg(3'd2, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
    in_e = 25'h3; cb = 25'h5;
    step(1'b1, 1'b1, 25'h0);
    load_cfg(cfg(3'd2, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    step(1'b1, 1'b1, 25'h1FFFFFE);

    // SHL, including shift amounts at and past the width
    load_cfg(cfg(3'd6, 3'd1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    in_e = 25'h1; cb = 25'd3;
    step(1'b1, 1'b1, 25'h8);
    chk("dl_ne_on", o1_dlne, 25'h8);
    cb = 25'd24;
    step(1'b1, 1'b1, 25'h1000000);
    cb = 25'd25;
    step(1'b1, 1'b1, 25'h0);
    cb = 25'd31;
    step(1'b1, 1'b1, 25'h0);

    // ACC with a bubble and a stall
    load_cfg(cfg(3'd7, 3'd1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
    clr_acc = 1'b1; run = 1'b0;
    @(posedge clk);
    #1;
    clr_acc = 1'b0;
    in_e = 25'h2;
    step(1'b1, 1'b1, 25'h2);
    step(1'b1, 1'b1, 25'h4);
    step(1'b0, 1'b1, 25'h0);
    step(1'b1, 1'b0, 25'h0);
    step(1'b1, 1'b1, 25'h6);
    step(1'b1, 1'b1, 25'h8);
    chk("dl_nw_acc", o1_dlnw, 25'h8);
    clr_acc = 1'b1; in_e = 25'h7;
    step(1'b1, 1'b1, 25'h7);

    // Shift XOR config in while ADD streams, commit mid-stream
    load_cfg(cfg(3'd1, 3'd1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    w_xor = cfg(3'd5, 3'd1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cb = 25'h0F0;
    for (int i = 0; i < 16; i++) begin
      conf_en = 1'b1;
      conf_in = w_xor[15-i];
      in_e    = 25'h0F0 + W'(i);
      step(1'b1, 1'b1, 25'h1E0 + W'(i));
    end
    conf_commit = 1'b1; in_e = 25'h100;
    step(1'b1, 1'b1, 25'h1F0);
    for (int i = 0; i < 4; i++) begin
      in_e = 25'h0F0 + W'(i);
      step(1'b1, 1'b1, W'(i));
    end

    // Commit together with a shift takes the pre-shift word
    w_b = cfg(3'd5, 3'd2, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    load_cfg(w_b, 1'b0);
    conf_en = 1'b1; conf_in = 1'b1; conf_commit = 1'b1;
    @(posedge clk);
    #1;
    conf_en = 1'b0; conf_commit = 1'b0;
    in_w = 25'h0FF; cb = 25'h0F0;
    step(1'b1, 1'b1, 25'h00F);

    // LAT=3 item delayed by a two-cycle stall: five clocks to emerge
    in_w = 25'h0AA;
    step(1'b1, 1'b1, 25'h05A);
    step(1'b0, 1'b1, 25'h0);
    step(1'b0, 1'b0, 25'h0);
    step(1'b0, 1'b0, 25'h0);
    step(1'b0, 1'b1, 25'h0);
    chk("lat3_stall_data", o3_data, 25'h05A);

    // Asynchronous reset mid-stream
    step(1'b1, 1'b1, 25'h05A);
    step(1'b1, 1'b1, 25'h05A);
    #2 rst_n = 1'b0;
    #1;
    chkb("arst_valid1", o1_valid, 1'b0);
    chkb("arst_valid3", o3_valid, 1'b0);
    chk("arst_data1", o1_data, '0);
    chk("arst_data3", o3_data, '0);
    reset_model();
    @(negedge clk) rst_n = 1'b1;
    in_s = 25'h123;
    step(1'b1, 1'b1, 25'h123);
    chk("post_rst_dl", o1_dln | o1_dlne | o1_dlnw, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
